dt_skeleton: RTL and testbench

- Downstream consumer of the distance-transform result RAM: a 128x128 image, 8-bit distance per pixel, pixel index = y*128 + x.
- Once the distance-transform stage finishes, this block scans the map and extracts the medial-axis skeleton, i.e. the 8-neighbour local maxima.
- The skeleton is packed as a 1-bit image into 16-bit words, in the same layout as the source binary image, and written to a skeleton RAM.
- It also reports the maximum distance and the skeleton pixel count.

---
 rtl/dt_skeleton.sv | 203 ++++++++++++++++++++
 tb/tb_dt_skeleton.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dt_skeleton.sv
// dt_skeleton: scans a finished distance-transform map and extracts the
// medial-axis skeleton (8-neighbour local maxima). The skeleton is packed
// MSB-first into 16-bit words and written to a skeleton RAM, and the largest
// distance plus the number of skeleton pixels are reported at the end.
module dt_skeleton #(
    parameter int IMG_W = 128,
    parameter int DW    = 8,
    localparam int XW   = $clog2(IMG_W),
    localparam int AW   = 2 * XW,
    localparam int WAW  = AW - 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic           res_rd,
    output logic [AW-1:0]  res_addr,
    input  logic [DW-1:0]  res_di,
    output logic           skel_wr,
    output logic [WAW-1:0] skel_addr,
    output logic [15:0]    skel_do,
    output logic           done,
    output logic [DW-1:0]  max_dist,
    output logic [AW-1:0]  skel_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_C,
        S_RD_N,
        S_WR,
        S_FINISH
    } state_t;

    localparam logic [XW-1:0] X_LAST = {XW{1'b1}};

    state_t         state_q, state_d;
    logic [AW-1:0]  p_q, p_d;
    logic [2:0]     k_q, k_d;
    logic [DW-1:0]  c_q, c_d;
    logic           keep_q, keep_d;
    logic [15:0]    word_q, word_d;
    logic [DW-1:0]  max_q, max_d;
    logic [AW-1:0]  cnt_q, cnt_d;

    // Pixel coordinates of the pixel being evaluated
    logic [XW-1:0]  pix_x;
    logic [XW-1:0]  pix_y;
    assign pix_x = p_q[XW-1:0];
    assign pix_y = p_q[AW-1:XW];

    // Word that has just been completed; p already points past its last pixel
    logic [WAW-1:0] word_addr;
    assign word_addr = p_q[AW-1:4] - WAW'(1);

    // Neighbour geometry for step k (NW, N, NE, W, E, SW, S, SE)
    logic           dx_neg, dx_pos, dy_neg, dy_pos;
    logic           nb_in;
    logic [XW-1:0]  nb_x, nb_y;
    logic [AW-1:0]  nb_addr;
    logic [DW-1:0]  nb_val;

    // Decode the direction of the current neighbour and whether it lies on the image
    always_comb begin
        dx_neg = 1'b0;
        dx_pos = 1'b0;
        dy_neg = 1'b0;
        dy_pos = 1'b0;
        case (k_q)
            3'd0: begin dx_neg = 1'b1; dy_neg = 1'b1; end
            3'd1: begin dy_neg = 1'b1; end
            3'd2: begin dx_pos = 1'b1; dy_neg = 1'b1; end
            3'd3: begin dx_neg = 1'b1; end
            3'd4: begin dx_pos = 1'b1; end
            3'd5: begin dx_neg = 1'b1; dy_pos = 1'b1; end
            3'd6: begin dy_pos = 1'b1; end
            default: begin dx_pos = 1'b1; dy_pos = 1'b1; end
        endcase

        nb_in = 1'b1;
        if (dx_neg && (pix_x == '0))     nb_in = 1'b0;
        if (dx_pos && (pix_x == X_LAST)) nb_in = 1'b0;
        if (dy_neg && (pix_y == '0))     nb_in = 1'b0;
        if (dy_pos && (pix_y == X_LAST)) nb_in = 1'b0;

        nb_x = pix_x;
        if (dx_neg) nb_x = pix_x - XW'(1);
        if (dx_pos) nb_x = pix_x + XW'(1);
        nb_y = pix_y;
        if (dy_neg) nb_y = pix_y - XW'(1);
        if (dy_pos) nb_y = pix_y + XW'(1);

        nb_addr = {nb_y, nb_x};
        nb_val  = nb_in ? res_di : '0;
    end

    // Next-state, datapath updates and outputs of the scan FSM
    always_comb begin
        logic pix_end;
        logic keep_final;
        logic keep_now;

        state_d    = state_q;
        p_d        = p_q;
        k_d        = k_q;
        c_d        = c_q;
        keep_d     = keep_q;
        word_d     = word_q;
        max_d      = max_q;
        cnt_d      = cnt_q;
        res_rd     = 1'b0;
        res_addr   = '0;
        skel_wr    = 1'b0;
        skel_addr  = '0;
        skel_do    = '0;
        done       = 1'b0;
        pix_end    = 1'b0;
        keep_final = 1'b0;
        keep_now   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RD_C;
            end

            S_RD_C: begin
                res_rd   = 1'b1;
                res_addr = p_q;
                c_d      = res_di;
                keep_d   = (res_di != '0);
                k_d      = 3'd0;
                if (res_di > max_q) max_d = res_di;
                if (res_di == '0) begin
                    pix_end    = 1'b1;
                    keep_final = 1'b0;
                end else begin
                    state_d = S_RD_N;
                end
            end

            S_RD_N: begin
                res_rd   = nb_in;
                res_addr = nb_in ? nb_addr : '0;
                keep_now = keep_q && !(nb_val > c_q);
                keep_d   = keep_now;
                k_d      = k_q + 3'd1;
                if (k_q == 3'd7) begin
                    pix_end    = 1'b1;
                    keep_final = keep_now;
                end
            end

            S_WR: begin
                skel_wr   = 1'b1;
                skel_addr = word_addr;
                skel_do   = word_q;
                word_d    = '0;
                state_d   = (&word_addr) ? S_FINISH : S_RD_C;
            end

            S_FINISH: begin
                done = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (pix_end) begin
            word_d  = {word_q[14:0], keep_final};
            cnt_d   = cnt_q + {{(AW-1){1'b0}}, keep_final};
            p_d     = p_q + AW'(1);
            state_d = (p_q[3:0] == 4'hF) ? S_WR : S_RD_C;
        end
    end

    // State and datapath registers with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            k_q     <= '0;
            c_q     <= '0;
            keep_q  <= 1'b0;
            word_q  <= '0;
            max_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            k_q     <= k_d;
            c_q     <= c_d;
            keep_q  <= keep_d;
            word_q  <= word_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
        end
    end

    assign max_dist = max_q;
    assign skel_cnt = cnt_q;

endmodule

// File: tb/tb_dt_skeleton.sv
// tb_dt_skeleton: scoreboard bench for dt_skeleton. A reference model derives
// every skeleton word, the read count, the maximum, the pixel count and the
// scan length straight from the local-maximum rule; a monitor pops expected
// writes whenever the DUT writes a skeleton word.
module tb_dt_skeleton;

    localparam int IMG_W  = 128;
    localparam int NPIX   = IMG_W * IMG_W;
    localparam int NWORDS = NPIX / 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        res_rd;
    logic [13:0] res_addr;
    logic [7:0]  res_di;
    logic        skel_wr;
    logic [9:0]  skel_addr;
    logic [15:0] skel_do;
    logic        done;
    logic [7:0]  max_dist;
    logic [13:0] skel_cnt;

    dt_skeleton #(.IMG_W(IMG_W), .DW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .res_rd    (res_rd),
        .res_addr  (res_addr),
        .res_di    (res_di),
        .skel_wr   (skel_wr),
        .skel_addr (skel_addr),
        .skel_do   (skel_do),
        .done      (done),
        .max_dist  (max_dist),
        .skel_cnt  (skel_cnt)
    );

    always #5 clk = ~clk;

    // Distance RAM model; unrequested reads return noise so ignored data cannot hide
    logic [7:0] mem [NPIX];
    logic [7:0] garbage = 8'h00;
    always @(negedge clk) garbage = 8'($urandom);
    assign res_di = res_rd ? mem[res_addr] : garbage;

    typedef struct {
        logic [9:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [15:0] obs_words [NWORDS];
    int          total = 0;
    int          bad = 0;
    int          wr_seen = 0;
    int          rd_seen = 0;
    int          idle_viol = 0;
    int          exp_max, exp_cnt, exp_cycles, exp_reads;

    // Monitor: count reads, watch idle outputs, pop and compare every write
    always @(posedge clk) begin
        #1;
        if (res_rd) rd_seen++;
        else if (res_addr != 14'd0) idle_viol++;
        if (skel_wr) begin
            wr_seen++;
            obs_words[skel_addr] = skel_do;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_write: got addr=%0d data=%04h, required no write", skel_addr, skel_do);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.addr !== skel_addr || mon_e.data !== skel_do) begin
                    bad++;
                    $display("[TB] FAIL skel_write: got addr=%0d data=%04h, required addr=%0d data=%04h",
                             skel_addr, skel_do, mon_e.addr, mon_e.data);
                end
            end
        end else if (skel_addr != 10'd0 || skel_do != 16'd0) begin
            idle_viol++;
        end
    end

    task automatic checkOutput(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Reference model: a pixel is skeleton if nonzero and no on-image neighbour exceeds it
    task automatic buildModel();
        int nz;
        int cnt;
        exp_q.delete();
        exp_max = 0; cnt = 0; nz = 0; exp_reads = 0;
        for (int w = 0; w < NWORDS; w++) begin
            wr_t e;
            e.addr = 10'(w);
            e.data = 16'h0000;
            for (int b = 0; b < 16; b++) begin
                int pix, x, y, c;
                bit keep;
                pix = w * 16 + b;
                x = pix % IMG_W;
                y = pix / IMG_W;
                c = int'(mem[pix]);
                keep = (c != 0);
                exp_reads++;
                if (c > exp_max) exp_max = c;
                if (c != 0) begin
                    nz++;
                    for (int dy = -1; dy <= 1; dy++) begin
                        for (int dx = -1; dx <= 1; dx++) begin
                            int nx, ny;
                            nx = x + dx;
                            ny = y + dy;
                            if ((dx != 0 || dy != 0) && nx >= 0 && nx < IMG_W && ny >= 0 && ny < IMG_W) begin
                                exp_reads++;
                                if (int'(mem[ny * IMG_W + nx]) > c) keep = 0;
                            end
                        end
                    end
                end
                if (keep) cnt++;
                e.data[15 - b] = keep;
            end
            exp_q.push_back(e);
        end
        exp_cnt    = cnt % NPIX;
        exp_cycles = 1 + NPIX + NWORDS + 8 * nz;
    endtask

    task automatic clearCounters();
        wr_seen = 0; rd_seen = 0; idle_viol = 0;
        for (int i = 0; i < NWORDS; i++) obs_words[i] = 16'h0000;
    endtask

    // Pulse start, count edges from the sampling edge until done rises
    task automatic applyStimulus(output int cycles);
        buildModel();
        @(negedge clk);
        clearCounters();
        start = 1'b1;
        @(posedge clk);
        cycles = 1;
        #1 start = 1'b0;
        while (!done && cycles < exp_cycles + 64) begin
            @(posedge clk);
            cycles++;
            #1;
        end
        @(negedge clk);
    endtask

    task automatic checkScan(input string tag, input int cycles);
        checkOutput({tag, "_done"}, done, 1);
        checkOutput({tag, "_cycles"}, cycles, exp_cycles);
        checkOutput({tag, "_max_dist"}, max_dist, exp_max);
        checkOutput({tag, "_skel_cnt"}, skel_cnt, exp_cnt);
        checkOutput({tag, "_writes"}, wr_seen, NWORDS);
        checkOutput({tag, "_pending"}, exp_q.size(), 0);
        checkOutput({tag, "_reads"}, rd_seen, exp_reads);
        checkOutput({tag, "_idle_outputs"}, idle_viol, 0);
    endtask

    task automatic resetDut();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clearMem();
        for (int i = 0; i < NPIX; i++) mem[i] = 8'd0;
    endtask

    initial begin
        int cycles;
        int snap_wr, snap_rd, guard;
        reset = 1'b1;
        start = 1'b0;
        clearMem();
        clearCounters();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_done", done, 0);
        checkOutput("reset_max", max_dist, 0);
        checkOutput("reset_cnt", skel_cnt, 0);
        checkOutput("reset_rd", res_rd, 0);
        checkOutput("reset_wr", skel_wr, 0);
        @(negedge clk);
        reset = 1'b0;

        // All-zero map
        $display("[TB] scan: all-zero map");
        applyStimulus(cycles);
        checkScan("zero", cycles);
        checkOutput("zero_cycles_const", cycles, 17409);

        // FINISH holds done and ignores start
        snap_wr = wr_seen; snap_rd = rd_seen;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("finish_done_hold", done, 1);
        checkOutput("finish_no_writes", wr_seen, snap_wr);
        checkOutput("finish_no_reads", rd_seen, snap_rd);

        // Directed features: corner, single pixel, plateau, ramps
        resetDut();
        clearMem();
        mem[0]                = 8'd3;
        mem[5 * IMG_W + 5]    = 8'd1;
        mem[10 * IMG_W + 16]  = 8'd2;
        mem[10 * IMG_W + 17]  = 8'd2;
        mem[11 * IMG_W + 16]  = 8'd2;
        mem[11 * IMG_W + 17]  = 8'd2;
        mem[20 * IMG_W + 40]  = 8'd5;
        mem[20 * IMG_W + 41]  = 8'd6;
        mem[40 * IMG_W + 40]  = 8'd5;
        mem[40 * IMG_W + 41]  = 8'd6;
        $display("[TB] scan: directed features");
        applyStimulus(cycles);
        checkScan("directed", cycles);
        checkOutput("word0_corner", obs_words[0], 16'h8000);
        checkOutput("word40_single", obs_words[40], 16'h0400);
        checkOutput("word81_plateau", obs_words[81], 16'hC000);
        checkOutput("word89_plateau", obs_words[89], 16'hC000);
        checkOutput("word162_ramp", obs_words[162], 16'h0040);
        checkOutput("word322_ramp", obs_words[322], 16'h0040);
        checkOutput("directed_max_const", max_dist, 6);
        checkOutput("directed_cnt_const", skel_cnt, 8);

        // Random clusters including border pixels
        resetDut();
        clearMem();
        for (int i = 0; i < 40; i++) begin
            int p;
            p = int'($urandom_range(0, NPIX - 1));
            mem[p] = 8'($urandom_range(1, 9));
            if ($urandom_range(0, 1) == 1) mem[(p + 1) % NPIX] = 8'($urandom_range(1, 9));
            if ($urandom_range(0, 1) == 1) mem[(p + IMG_W) % NPIX] = 8'($urandom_range(1, 9));
        end
        mem[IMG_W - 1]          = 8'($urandom_range(1, 255));
        mem[NPIX - 1]           = 8'($urandom_range(1, 255));
        mem[NPIX - IMG_W]       = 8'($urandom_range(1, 255));
        mem[NPIX - IMG_W + 1]   = 8'($urandom_range(1, 255));
        mem[64 * IMG_W]         = 8'($urandom_range(1, 255));
        mem[64 * IMG_W + 127]   = 8'($urandom_range(1, 255));
        $display("[TB] scan: random clusters");
        applyStimulus(cycles);
        checkScan("random", cycles);

        // Reset after 300 writes, then a fresh scan of the zero map
        resetDut();
        clearMem();
        buildModel();
        @(negedge clk);
        clearCounters();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (wr_seen < 300 && guard < 300 * 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("midscan_reached_300", (wr_seen >= 300) ? 1 : 0, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midreset_res_rd", res_rd, 0);
        checkOutput("midreset_res_addr", res_addr, 0);
        checkOutput("midreset_skel_wr", skel_wr, 0);
        checkOutput("midreset_skel_addr", skel_addr, 0);
        checkOutput("midreset_skel_do", skel_do, 0);
        checkOutput("midreset_done", done, 0);
        checkOutput("midreset_max", max_dist, 0);
        checkOutput("midreset_cnt", skel_cnt, 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        snap_wr = wr_seen; snap_rd = rd_seen;
        repeat (5) @(negedge clk);
        checkOutput("postreset_idle_writes", wr_seen, snap_wr);
        checkOutput("postreset_idle_reads", rd_seen, snap_rd);
        checkOutput("postreset_idle_done", done, 0);

        $display("[TB] scan: zero map after reset");
        applyStimulus(cycles);
        checkScan("restart", cycles);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required done earlier");
        $fatal(1, "[TB] watchdog");
    end

endmodule
